// File: rtl/stack_pointer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : stack_pointer_ctrl
//  Brief    : Stack pointer sequencer for PUSH/POP requests. Owns the 10-bit
//             empty-descending SP and runs the data-memory handshake for each
//             stack access. Also tracks full/empty and keeps sticky
//             overflow/underflow flags.
//  Revision : 1.0 - initial release
// ============================================================================
module stack_pointer_ctrl #(
    parameter logic [9:0] STACK_BASE  = 10'h3FE,
    parameter logic [9:0] STACK_LIMIT = 10'h200,
    parameter int         DATA_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_req,
    input  logic              pop_req,
    input  logic [DATA_W-1:0] push_data,
    input  logic              sp_load,
    input  logic [9:0]        sp_load_val,
    input  logic              clr_err,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [9:0]        mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    output logic [DATA_W-1:0] pop_data,
    output logic [9:0]        sp,
    output logic              busy,
    output logic              done,
    output logic              full,
    output logic              empty,
    output logic              overflow_err,
    output logic              underflow_err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WRITE = 3'd1;
    localparam logic [2:0] S_INC   = 3'd2;
    localparam logic [2:0] S_READ  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [9:0] c_SP_STEP   = 10'd2;
    localparam logic [9:0] c_EVEN_MASK = 10'h3FE;

    logic [2:0]        r_state;
    logic [9:0]        r_sp;
    logic [9:0]        r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_pop_data;
    logic              r_ovf;
    logic              r_unf;

    logic [2:0]        w_state_next;
    logic [9:0]        w_sp_next;
    logic [9:0]        w_addr_next;
    logic [DATA_W-1:0] w_wdata_next;
    logic [DATA_W-1:0] w_pop_next;
    logic              w_ovf_set;
    logic              w_unf_set;
    logic              w_full;
    logic              w_empty;

    assign w_full  = (r_sp == STACK_LIMIT);
    assign w_empty = (r_sp == STACK_BASE);

    // Next-state and datapath update; IDLE arbitrates load > push > pop.
    always_comb begin
        w_state_next = r_state;
        w_sp_next    = r_sp;
        w_addr_next  = r_mem_addr;
        w_wdata_next = r_mem_wdata;
        w_pop_next   = r_pop_data;
        w_ovf_set    = 1'b0;
        w_unf_set    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (sp_load) begin
                    // Odd addresses are not word aligned, so bit 0 is dropped.
                    w_sp_next = sp_load_val & c_EVEN_MASK;
                end else if (push_req) begin
                    if (w_full) begin
                        w_ovf_set    = 1'b1;
                        w_state_next = S_DONE;
                    end else begin
                        w_wdata_next = push_data;
                        w_addr_next  = r_sp;
                        w_state_next = S_WRITE;
                    end
                end else if (pop_req) begin
                    if (w_empty) begin
                        w_unf_set    = 1'b1;
                        w_state_next = S_DONE;
                    end else begin
                        w_sp_next    = r_sp + c_SP_STEP;
                        w_state_next = S_INC;
                    end
                end
            end
            S_WRITE: begin
                if (mem_ready) begin
                    w_sp_next    = r_sp - c_SP_STEP;
                    w_state_next = S_DONE;
                end
            end
            S_INC: begin
                w_addr_next  = r_sp;
                w_state_next = S_READ;
            end
            S_READ: begin
                if (mem_ready) begin
                    w_pop_next   = mem_rdata;
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any in-flight access.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_sp        <= STACK_BASE;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_pop_data  <= '0;
            r_ovf       <= 1'b0;
            r_unf       <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_sp        <= w_sp_next;
            r_mem_addr  <= w_addr_next;
            r_mem_wdata <= w_wdata_next;
            r_pop_data  <= w_pop_next;
            // A new error beats a simultaneous clear.
            r_ovf       <= w_ovf_set | (r_ovf & ~clr_err);
            r_unf       <= w_unf_set | (r_unf & ~clr_err);
        end
    end

    assign mem_addr      = r_mem_addr;
    assign mem_wdata     = r_mem_wdata;
    assign mem_we        = (r_state == S_WRITE);
    assign mem_re        = (r_state == S_READ);
    assign pop_data      = r_pop_data;
    assign sp            = r_sp;
    assign busy          = (r_state != S_IDLE);
    assign done          = (r_state == S_DONE);
    assign full          = w_full;
    assign empty         = w_empty;
    assign overflow_err  = r_ovf;
    assign underflow_err = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_stack_pointer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stack_pointer_ctrl
//  Brief    : Directed self-checking bench for stack_pointer_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_stack_pointer_ctrl;

    logic        clk;
    logic        rst_n;
    logic        push_req;
    logic        pop_req;
    logic [15:0] push_data;
    logic        sp_load;
    logic [9:0]  sp_load_val;
    logic        clr_err;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic [9:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [15:0] pop_data;
    logic [9:0]  sp;
    logic        busy;
    logic        done;
    logic        full;
    logic        empty;
    logic        overflow_err;
    logic        underflow_err;

    int n_checks = 0;
    int n_fail   = 0;

    stack_pointer_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .push_req      (push_req),
        .pop_req       (pop_req),
        .push_data     (push_data),
        .sp_load       (sp_load),
        .sp_load_val   (sp_load_val),
        .clr_err       (clr_err),
        .mem_rdata     (mem_rdata),
        .mem_ready     (mem_ready),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_we        (mem_we),
        .mem_re        (mem_re),
        .pop_data      (pop_data),
        .sp            (sp),
        .busy          (busy),
        .done          (done),
        .full          (full),
        .empty         (empty),
        .overflow_err  (overflow_err),
        .underflow_err (underflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 ns after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; push_req = 1'b0; pop_req = 1'b0; push_data = '0;
        sp_load = 1'b0; sp_load_val = '0; clr_err = 1'b0;
        mem_rdata = '0; mem_ready = 1'b1;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        n_checks++; if (sp !== 10'h3FE) begin n_fail++; $display("FAIL reset_sp: got %h want 3fe", sp); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", empty); end
        n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", full); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if ({mem_we, mem_re, done} !== 3'b000) begin n_fail++; $display("FAIL reset_strobes: we/re/done got %b want 000", {mem_we, mem_re, done}); end
        n_checks++; if ({overflow_err, underflow_err} !== 2'b00) begin n_fail++; $display("FAIL reset_errs: got %b want 00", {overflow_err, underflow_err}); end
        n_checks++; if ({mem_addr, mem_wdata, pop_data} !== 42'd0) begin n_fail++; $display("FAIL reset_data: addr %h wdata %h pop %h want 0", mem_addr, mem_wdata, pop_data); end
    endtask

    task automatic test_push_pop();
        push_data = 16'hBEEF; push_req = 1'b1;
        tick();
        push_req = 1'b0;
        n_checks++; if ({mem_we, mem_re} !== 2'b10) begin n_fail++; $display("FAIL push_we: we/re got %b want 10", {mem_we, mem_re}); end
        n_checks++; if (mem_addr !== 10'h3FE || mem_wdata !== 16'hBEEF) begin n_fail++; $display("FAIL push_addr_data: got %h/%h want 3fe/beef", mem_addr, mem_wdata); end
        n_checks++; if (busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL push_busy: busy/done got %b%b want 10", busy, done); end
        tick();
        n_checks++; if (done !== 1'b1 || mem_we !== 1'b0) begin n_fail++; $display("FAIL push_done: done/we got %b%b want 10", done, mem_we); end
        n_checks++; if (sp !== 10'h3FC) begin n_fail++; $display("FAIL push_sp: got %h want 3fc", sp); end
        tick();
        n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL push_idle: done/busy got %b%b want 00", done, busy); end
        mem_rdata = 16'hBEEF; pop_req = 1'b1;
        tick();
        pop_req = 1'b0;
        n_checks++; if (sp !== 10'h3FE || mem_re !== 1'b0) begin n_fail++; $display("FAIL pop_inc: sp/re got %h/%b want 3fe/0", sp, mem_re); end
        tick();
        n_checks++; if (mem_re !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 10'h3FE) begin n_fail++; $display("FAIL pop_read: re/we/addr got %b/%b/%h want 1/0/3fe", mem_re, mem_we, mem_addr); end
        tick();
        n_checks++; if (done !== 1'b1 || mem_re !== 1'b0) begin n_fail++; $display("FAIL pop_done: done/re got %b%b want 10", done, mem_re); end
        n_checks++; if (pop_data !== 16'hBEEF) begin n_fail++; $display("FAIL pop_data: got %h want beef", pop_data); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL pop_empty: got %b want 1", empty); end
        mem_rdata = 16'h1234;
        tick();
        n_checks++; if (pop_data !== 16'hBEEF) begin n_fail++; $display("FAIL pop_hold: got %h want beef", pop_data); end
    endtask

    task automatic test_wait_states();
        int we_cycles = 0;
        int done_cnt  = 0;
        int bad       = 0;
        mem_ready = 1'b0; push_data = 16'hCAFE; push_req = 1'b1;
        tick();
        push_req = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (mem_we) begin
                we_cycles++;
                if (mem_addr !== 10'h3FE || mem_wdata !== 16'hCAFE || sp !== 10'h3FE) bad++;
                if (we_cycles == 4) mem_ready = 1'b1;
            end
            if (done) done_cnt++;
            tick();
        end
        n_checks++; if (we_cycles != 4) begin n_fail++; $display("FAIL wait_we_cycles: got %0d want 4", we_cycles); end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL wait_stable: %0d unstable cycles want 0", bad); end
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL wait_done_count: got %0d want 1", done_cnt); end
        n_checks++; if (sp !== 10'h3FC) begin n_fail++; $display("FAIL wait_sp: got %h want 3fc", sp); end
    endtask

    task automatic test_full();
        sp_load = 1'b1; sp_load_val = 10'h202;
        tick();
        sp_load = 1'b0;
        n_checks++; if (sp !== 10'h202 || busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL load_202: sp/busy/done got %h/%b/%b want 202/0/0", sp, busy, done); end
        push_data = 16'h1111; push_req = 1'b1;
        tick();
        push_req = 1'b0;
        n_checks++; if (mem_we !== 1'b1 || mem_addr !== 10'h202) begin n_fail++; $display("FAIL full_push_we: we/addr got %b/%h want 1/202", mem_we, mem_addr); end
        tick();
        n_checks++; if (sp !== 10'h200 || full !== 1'b1) begin n_fail++; $display("FAIL full_flag: sp/full got %h/%b want 200/1", sp, full); end
        tick();
        push_req = 1'b1;
        tick();
        push_req = 1'b0;
        n_checks++; if (done !== 1'b1 || mem_we !== 1'b0) begin n_fail++; $display("FAIL ovf_done: done/we got %b%b want 10", done, mem_we); end
        n_checks++; if (overflow_err !== 1'b1 || sp !== 10'h200) begin n_fail++; $display("FAIL ovf_flag: ovf/sp got %b/%h want 1/200", overflow_err, sp); end
        tick();
        n_checks++; if (overflow_err !== 1'b1 || busy !== 1'b0 || mem_we !== 1'b0) begin n_fail++; $display("FAIL ovf_sticky: ovf/busy/we got %b%b%b want 100", overflow_err, busy, mem_we); end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        n_checks++; if (overflow_err !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b want 0", overflow_err); end
    endtask

    task automatic test_underflow();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        pop_req = 1'b1;
        tick();
        pop_req = 1'b0;
        n_checks++; if (done !== 1'b1 || underflow_err !== 1'b1) begin n_fail++; $display("FAIL unf_flag: done/unf got %b%b want 11", done, underflow_err); end
        n_checks++; if (mem_re !== 1'b0 || sp !== 10'h3FE) begin n_fail++; $display("FAIL unf_noaccess: re/sp got %b/%h want 0/3fe", mem_re, sp); end
        tick();
        n_checks++; if (mem_re !== 1'b0 || busy !== 1'b0 || underflow_err !== 1'b1) begin n_fail++; $display("FAIL unf_sticky: re/busy/unf got %b%b%b want 001", mem_re, busy, underflow_err); end
        clr_err = 1'b1;
        tick();
        n_checks++; if (underflow_err !== 1'b0) begin n_fail++; $display("FAIL unf_clear: got %b want 0", underflow_err); end
        pop_req = 1'b1;
        tick();
        pop_req = 1'b0; clr_err = 1'b0;
        n_checks++; if (underflow_err !== 1'b1) begin n_fail++; $display("FAIL unf_vs_clear: got %b want 1", underflow_err); end
        tick();
        push_data = 16'h5A5A; push_req = 1'b1; pop_req = 1'b1;
        tick();
        push_req = 1'b0; pop_req = 1'b0;
        n_checks++; if ({mem_we, mem_re} !== 2'b10 || mem_wdata !== 16'h5A5A) begin n_fail++; $display("FAIL both_write: we/re got %b wdata %h want 10/5a5a", {mem_we, mem_re}, mem_wdata); end
        tick();
        n_checks++; if (done !== 1'b1 || sp !== 10'h3FC) begin n_fail++; $display("FAIL both_done: done/sp got %b/%h want 1/3fc", done, sp); end
        tick();
        n_checks++; if (mem_re !== 1'b0 || busy !== 1'b0 || sp !== 10'h3FC) begin n_fail++; $display("FAIL both_nopop: re/busy/sp got %b/%b/%h want 0/0/3fc", mem_re, busy, sp); end
    endtask

    task automatic test_reset_midop();
        mem_ready = 1'b0; pop_req = 1'b1;
        tick();
        pop_req = 1'b0;
        n_checks++; if (sp !== 10'h3FE || mem_re !== 1'b0) begin n_fail++; $display("FAIL mid_inc: sp/re got %h/%b want 3fe/0", sp, mem_re); end
        tick();
        n_checks++; if (mem_re !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL mid_read: re/busy got %b%b want 11", mem_re, busy); end
        rst_n = 1'b0;
        tick();
        n_checks++; if (mem_re !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || sp !== 10'h3FE) begin n_fail++; $display("FAIL mid_reset: re/busy/done/sp got %b/%b/%b/%h want 0/0/0/3fe", mem_re, busy, done, sp); end
        rst_n = 1'b1; mem_ready = 1'b1;
        tick();
        n_checks++; if (busy !== 1'b0 || mem_re !== 1'b0) begin n_fail++; $display("FAIL mid_after: busy/re got %b%b want 00", busy, mem_re); end
        sp_load = 1'b1; sp_load_val = 10'h155;
        tick();
        sp_load = 1'b0;
        n_checks++; if (sp !== 10'h154) begin n_fail++; $display("FAIL load_mask: got %h want 154", sp); end
        sp_load = 1'b1; sp_load_val = 10'h100; push_req = 1'b1;
        tick();
        sp_load = 1'b0; push_req = 1'b0;
        n_checks++; if (sp !== 10'h100 || mem_we !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL load_priority: sp/we/busy got %h/%b/%b want 100/0/0", sp, mem_we, busy); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_push_pop();
        test_wait_states();
        test_full();
        test_underflow();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
